// File: rtl/banked_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : banked_reg_bank
// Purpose  : ARMv4 register bank with full processor-mode banking.
//            There are 30 general physical registers plus a dedicated PC:
//              phys  0..14 : user/system R0-R14
//              phys 15..21 : FIQ R8_fiq-R14_fiq
//              phys 22..23 : IRQ R13/R14
//              phys 24..25 : SVC R13/R14
//              phys 26..27 : ABT R13/R14
//              phys 28..29 : UND R13/R14
//            The bank has three combinational read ports (Rn, Rm, Rs) and
//            one clocked write port. The PC (R15) has its own load and
//            auto-increment. user_bank forces the user mapping, which is
//            used for LDM/STM with the S bit.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            mode               - CPSR mode field (current cycle)
//            user_bank          - force user/system mapping on all ports
//            rn/rm/rs_sel/_data - read selects / combinational read data
//            rd_sel/_we/_data   - write port
//            pc_we, pc_data     - PC load
//            pc_inc             - PC advance by PC_INC
//            pc                 - current PC
//            mode_err           - mode encoding is not a legal ARMv4 mode
// Options  : REGBANK_BYPASS_EN  - when defined, the read ports see a
//                                 same-cycle rd_we write (write-through)
// Revision : 1.0 - initial release
// ============================================================================
module banked_reg_bank #(
    parameter int                 DATA_W   = 32,
    parameter int                 PC_INC   = 4,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mode,
    input  logic              user_bank,
    input  logic [3:0]        rn_sel,
    input  logic [3:0]        rm_sel,
    input  logic [3:0]        rs_sel,
    output logic [DATA_W-1:0] rn_data,
    output logic [DATA_W-1:0] rm_data,
    output logic [DATA_W-1:0] rs_data,
    input  logic [3:0]        rd_sel,
    input  logic              rd_we,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] pc_data,
    input  logic              pc_inc,
    output logic [DATA_W-1:0] pc,
    output logic              mode_err
);

    // CPSR mode encodings
    localparam logic [4:0] c_mode_usr = 5'b10000;
    localparam logic [4:0] c_mode_fiq = 5'b10001;
    localparam logic [4:0] c_mode_irq = 5'b10010;
    localparam logic [4:0] c_mode_svc = 5'b10011;
    localparam logic [4:0] c_mode_abt = 5'b10111;
    localparam logic [4:0] c_mode_und = 5'b11011;
    localparam logic [4:0] c_mode_sys = 5'b11111;

    // Internal bank identifiers (which physical set R8-R14 come from)
    localparam logic [2:0] c_bank_usr = 3'd0;
    localparam logic [2:0] c_bank_fiq = 3'd1;
    localparam logic [2:0] c_bank_irq = 3'd2;
    localparam logic [2:0] c_bank_svc = 3'd3;
    localparam logic [2:0] c_bank_abt = 3'd4;
    localparam logic [2:0] c_bank_und = 3'd5;

    localparam int              c_num_gpr = 30;
    localparam logic [3:0]      c_pc_sel  = 4'd15;
    localparam logic [DATA_W-1:0] c_pc_step = DATA_W'(PC_INC);

    logic [DATA_W-1:0] r_gpr [c_num_gpr];
    logic [DATA_W-1:0] r_pc;

    logic [2:0] w_bank;
    logic       w_mode_bad;
    logic [4:0] w_wr_phys;
    logic       w_wr_is_pc;

    // ------------------------------------------------------------------------
    // Logical-to-physical mapping. Selector 15 is never mapped here; callers
    // route it to the PC first.
    // ------------------------------------------------------------------------
    function automatic logic [4:0] f_map(input logic [3:0] sel, input logic [2:0] bank);
        logic [4:0] idx;
        idx = {1'b0, sel};
        if (bank == c_bank_fiq && sel >= 4'd8 && sel <= 4'd14) begin
            idx = {1'b0, sel} + 5'd7;               // R8 -> 15 ... R14 -> 21
        end else if (sel == 4'd13 || sel == 4'd14) begin
            case (bank)
                c_bank_irq: idx = {1'b0, sel} + 5'd9;   // R13 -> 22
                c_bank_svc: idx = {1'b0, sel} + 5'd11;  // R13 -> 24
                c_bank_abt: idx = {1'b0, sel} + 5'd13;  // R13 -> 26
                c_bank_und: idx = {1'b0, sel} + 5'd15;  // R13 -> 28
                default:    idx = {1'b0, sel};
            endcase
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------------
    // Mode decode. An illegal mode behaves exactly like user mode.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mode_bad = 1'b0;
        w_bank     = c_bank_usr;
        case (mode)
            c_mode_usr: w_bank = c_bank_usr;
            c_mode_sys: w_bank = c_bank_usr;
            c_mode_fiq: w_bank = c_bank_fiq;
            c_mode_irq: w_bank = c_bank_irq;
            c_mode_svc: w_bank = c_bank_svc;
            c_mode_abt: w_bank = c_bank_abt;
            c_mode_und: w_bank = c_bank_und;
            default:    w_mode_bad = 1'b1;
        endcase
        if (user_bank) begin
            w_bank = c_bank_usr;
        end
    end

    assign mode_err   = w_mode_bad;
    assign w_wr_is_pc = (rd_sel == c_pc_sel);
    assign w_wr_phys  = f_map(rd_sel, w_bank);

`ifdef REGBANK_BYPASS_EN
    // A write only counts for forwarding if it will actually commit.
    logic w_wr_act;
    assign w_wr_act = rd_we & ~rst;
`endif

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    logic [3:0]             w_rd_sel [3];
    logic [2:0][DATA_W-1:0] w_rd_val;

    assign w_rd_sel[0] = rn_sel;
    assign w_rd_sel[1] = rm_sel;
    assign w_rd_sel[2] = rs_sel;

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd_port
        logic [4:0]        w_phys;
        logic [DATA_W-1:0] w_val;

        assign w_phys = f_map(w_rd_sel[gi], w_bank);

        always_comb begin
            if (w_rd_sel[gi] == c_pc_sel) begin
                w_val = r_pc;
            end else begin
                w_val = r_gpr[w_phys];
            end
`ifdef REGBANK_BYPASS_EN
            if (w_wr_act) begin
                if (w_rd_sel[gi] == c_pc_sel) begin
                    if (w_wr_is_pc) begin
                        w_val = rd_data;
                    end
                end else if (!w_wr_is_pc && w_phys == w_wr_phys) begin
                    w_val = rd_data;
                end
            end
`endif
        end

        assign w_rd_val[gi] = w_val;
    end

    assign rn_data = w_rd_val[0];
    assign rm_data = w_rd_val[1];
    assign rs_data = w_rd_val[2];
    assign pc      = r_pc;

    // ------------------------------------------------------------------------
    // General register write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_num_gpr; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (rd_we && !w_wr_is_pc) begin
            r_gpr[w_wr_phys] <= rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Program counter: a data-path write to R15 wins over an explicit load,
    // which wins over auto-increment. The increment wraps naturally.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (rd_we && w_wr_is_pc) begin
            r_pc <= rd_data;
        end else if (pc_we) begin
            r_pc <= pc_data;
        end else if (pc_inc) begin
            r_pc <= r_pc + c_pc_step;
        end
    end

endmodule
`default_nettype wire
